hv_pair_loader: RTL and testbench

//  Upstream feeder and result collector for FP_Cosine_Similarity.
//  - Takes one FP32 hypervector element per handshake over a serial stream.
//  - Assembles N elements of A, then N elements of B, into the flat buses.
//  - Asserts the per-element valid masks and holds them until cos_valid.
//  - Returns cos_theta, or a timeout marker, on a valid/ready result port.

---
 rtl/hv_pair_loader.sv | 175 +++++++++++++++++
 tb/tb_hv_pair_loader.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/hv_pair_loader.sv
// Serial FP32 feeder for the cosine-similarity unit: assembles vectors A and B
// from a valid/ready stream, raises the element masks, then returns the result or a timeout marker.
module hv_pair_loader #(
    parameter  int N       = 100,
    parameter  int TIMEOUT = 4095,
    localparam int IDX_W   = $clog2(N),
    localparam int TMO_W   = $clog2(TIMEOUT + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     s_data,
    input  logic            s_valid,
    output logic            s_ready,
    output logic [32*N-1:0] A_flat,
    output logic [32*N-1:0] B_flat,
    output logic [N-1:0]    A_valid_out,
    output logic [N-1:0]    B_valid_out,
    input  logic [31:0]     cos_theta,
    input  logic            cos_valid,
    output logic [31:0]     r_data,
    output logic            r_valid,
    input  logic            r_ready,
    output logic            r_timeout,
    output logic            busy
);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        WAIT   = 2'd2,
        RESULT = 2'd3
    } state_t;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    state_t            state_r, state_nx_s;
    logic [IDX_W-1:0]  idx_r, idx_nx_s;
    logic [TMO_W-1:0]  tmo_cnt_r, tmo_nx_s;
    logic [N-1:0]      mask_r, mask_nx_s;
    logic [31:0]       r_data_r, r_data_nx_s;
    logic              r_valid_r, r_valid_nx_s;
    logic              r_timeout_r, r_timeout_nx_s;
    logic              busy_r, busy_nx_s;
    logic [32*N-1:0]   a_flat_r, b_flat_r;
    logic              s_ready_s, hs_s, last_s, a_we_s, b_we_s;

    assign s_ready_s = (state_r == LOAD_A) || (state_r == LOAD_B);
    assign hs_s      = s_valid && s_ready_s;
    assign last_s    = (idx_r == IDX_W'(N - 1));

    // Next-state, counter and result-capture decode
    always_comb begin
        state_nx_s     = state_r;
        idx_nx_s       = idx_r;
        tmo_nx_s       = tmo_cnt_r;
        mask_nx_s      = mask_r;
        r_data_nx_s    = r_data_r;
        r_valid_nx_s   = r_valid_r;
        r_timeout_nx_s = r_timeout_r;
        a_we_s         = 1'b0;
        b_we_s         = 1'b0;
        case (state_r)
            LOAD_A: begin
                if (hs_s) begin
                    a_we_s = 1'b1;
                    if (last_s) begin
                        idx_nx_s   = {IDX_W{1'b0}};
                        state_nx_s = LOAD_B;
                    end else begin
                        idx_nx_s = idx_r + IDX_W'(1);
                    end
                end else begin
                    idx_nx_s = idx_r;
                end
            end
            LOAD_B: begin
                if (hs_s) begin
                    b_we_s = 1'b1;
                    if (last_s) begin
                        idx_nx_s   = {IDX_W{1'b0}};
                        tmo_nx_s   = {TMO_W{1'b0}};
                        mask_nx_s  = {N{1'b1}};
                        state_nx_s = WAIT;
                    end else begin
                        idx_nx_s = idx_r + IDX_W'(1);
                    end
                end else begin
                    idx_nx_s = idx_r;
                end
            end
            WAIT: begin
                tmo_nx_s = tmo_cnt_r + TMO_W'(1);
                // A genuine result takes priority over an expiring timeout
                if (cos_valid) begin
                    r_data_nx_s    = cos_theta;
                    r_timeout_nx_s = 1'b0;
                    r_valid_nx_s   = 1'b1;
                    mask_nx_s      = {N{1'b0}};
                    state_nx_s     = RESULT;
                end else if (tmo_cnt_r == TMO_W'(TIMEOUT - 1)) begin
                    r_data_nx_s    = QNAN;
                    r_timeout_nx_s = 1'b1;
                    r_valid_nx_s   = 1'b1;
                    mask_nx_s      = {N{1'b0}};
                    state_nx_s     = RESULT;
                end else begin
                    state_nx_s = WAIT;
                end
            end
            RESULT: begin
                if (r_ready) begin
                    r_valid_nx_s   = 1'b0;
                    r_timeout_nx_s = 1'b0;
                    state_nx_s     = LOAD_A;
                end else begin
                    state_nx_s = RESULT;
                end
            end
            default: begin
                state_nx_s = LOAD_A;
                idx_nx_s   = {IDX_W{1'b0}};
            end
        endcase
        busy_nx_s = !((state_nx_s == LOAD_A) && (idx_nx_s == {IDX_W{1'b0}}));
    end

    // State, counters, masks and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= LOAD_A;
            idx_r       <= {IDX_W{1'b0}};
            tmo_cnt_r   <= {TMO_W{1'b0}};
            mask_r      <= {N{1'b0}};
            r_data_r    <= 32'h0000_0000;
            r_valid_r   <= 1'b0;
            r_timeout_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            idx_r       <= idx_nx_s;
            tmo_cnt_r   <= tmo_nx_s;
            mask_r      <= mask_nx_s;
            r_data_r    <= r_data_nx_s;
            r_valid_r   <= r_valid_nx_s;
            r_timeout_r <= r_timeout_nx_s;
            busy_r      <= busy_nx_s;
        end
    end

    // Element storage; never cleared between pairs since each load overwrites all of it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_flat_r <= {(32*N){1'b0}};
            b_flat_r <= {(32*N){1'b0}};
        end else begin
            if (a_we_s) begin
                a_flat_r[32*idx_r +: 32] <= s_data;
            end
            if (b_we_s) begin
                b_flat_r[32*idx_r +: 32] <= s_data;
            end
        end
    end

    assign s_ready     = s_ready_s;
    assign A_flat      = a_flat_r;
    assign B_flat      = b_flat_r;
    assign A_valid_out = mask_r;
    assign B_valid_out = mask_r;
    assign r_data      = r_data_r;
    assign r_valid     = r_valid_r;
    assign r_timeout   = r_timeout_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_hv_pair_loader.sv
// Directed-plus-random bench for hv_pair_loader (N=4, TIMEOUT=16); expected
// buses come from arrays of the words sent, timing from cycle counts.
module tb_hv_pair_loader;

    localparam int N       = 4;
    localparam int TIMEOUT = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [31:0]     s_data;
    logic            s_valid;
    logic            s_ready;
    logic [32*N-1:0] A_flat, B_flat;
    logic [N-1:0]    A_valid_out, B_valid_out;
    logic [31:0]     cos_theta;
    logic            cos_valid;
    logic [31:0]     r_data;
    logic            r_valid;
    logic            r_ready;
    logic            r_timeout;
    logic            busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl_a [N];
    logic [31:0] mdl_b [N];

    hv_pair_loader #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .A_flat(A_flat), .B_flat(B_flat),
        .A_valid_out(A_valid_out), .B_valid_out(B_valid_out),
        .cos_theta(cos_theta), .cos_valid(cos_valid),
        .r_data(r_data), .r_valid(r_valid), .r_ready(r_ready),
        .r_timeout(r_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [32*N-1:0] flat_of_a();
        logic [32*N-1:0] f;
        for (int k = 0; k < N; k++) f[32*k +: 32] = mdl_a[k];
        return f;
    endfunction

    function automatic logic [32*N-1:0] flat_of_b();
        logic [32*N-1:0] f;
        for (int k = 0; k < N; k++) f[32*k +: 32] = mdl_b[k];
        return f;
    endfunction

    // Present one word from a negedge and return at the negedge after it is consumed
    task automatic send_word(input logic [31:0] d);
        int cnt;
        s_data  = d;
        s_valid = 1'b1;
        cnt = 0;
        while (!s_ready && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 100) begin
            checks++;
            errors++;
            $error("FAIL send_timeout observed=%0d expected<100", cnt);
        end
        @(negedge clk);
    endtask

    // Stream the model's A then B words; returns one cycle after the last handshake
    task automatic load_pair();
        for (int k = 0; k < N; k++) send_word(mdl_a[k]);
        for (int k = 0; k < N; k++) send_word(mdl_b[k]);
        s_valid = 1'b0;
    endtask

    task automatic randomize_pair();
        for (int k = 0; k < N; k++) begin
            mdl_a[k] = $urandom;
            mdl_b[k] = $urandom;
        end
    endtask

    task automatic wait_result(output int cycles);
        cycles = 0;
        while (!r_valid && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic release_result(input string tag);
        r_ready = 1'b1;
        @(negedge clk);
        r_ready = 1'b0;
        check({tag, "_rvalid_clr"}, r_valid, 1'b0);
        check({tag, "_rtmo_clr"}, r_timeout, 1'b0);
        check({tag, "_sready"}, s_ready, 1'b1);
    endtask

    int          cyc;
    logic [31:0] w;
    logic [31:0] cv;

    initial begin
        rst_n = 1'b0; s_data = 32'h0; s_valid = 1'b0;
        cos_theta = 32'h0; cos_valid = 1'b0; r_ready = 1'b0;
        #12;
        check("rst_aflat", A_flat, 128'h0);
        check("rst_bflat", B_flat, 128'h0);
        check("rst_masks", {A_valid_out, B_valid_out}, 8'h00);
        check("rst_result", {r_data, r_valid, r_timeout, busy}, 35'h0);
        check("rst_sready", s_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: known values, masks one cycle after the eighth handshake
        mdl_a[0] = 32'h3F80_0000; mdl_a[1] = 32'h4000_0000;
        mdl_a[2] = 32'h4040_0000; mdl_a[3] = 32'h4080_0000;
        for (int k = 0; k < N; k++) mdl_b[k] = 32'h3F80_0000;
        s_data = mdl_a[0]; s_valid = 1'b1;
        @(negedge clk);
        check("t1_busy_loading", busy, 1'b1);
        for (int k = 1; k < N; k++) send_word(mdl_a[k]);
        for (int k = 0; k < N; k++) begin
            check("t1_mask_low", A_valid_out, 4'h0);
            send_word(mdl_b[k]);
        end
        s_valid = 1'b0;
        check("t1_aflat", A_flat, 128'h40800000_40400000_40000000_3F800000);
        check("t1_bflat", B_flat, flat_of_b());
        check("t1_amask", A_valid_out, 4'hF);
        check("t1_bmask", B_valid_out, 4'hF);
        check("t1_sready_wait", s_ready, 1'b0);

        // 2: result five cycles into WAIT
        repeat (5) @(negedge clk);
        check("t2_rvalid_pre", r_valid, 1'b0);
        cos_valid = 1'b1; cos_theta = 32'h3F80_0000;
        @(negedge clk);
        cos_valid = 1'b0;
        check("t2_rvalid", r_valid, 1'b1);
        check("t2_rdata", r_data, 32'h3F80_0000);
        check("t2_rtmo", r_timeout, 1'b0);
        check("t2_masks", {A_valid_out, B_valid_out}, 8'h00);
        cos_valid = 1'b1; cos_theta = 32'h1234_5678;
        @(negedge clk);
        cos_valid = 1'b0;
        check("t2_cos_ignored", r_data, 32'h3F80_0000);
        release_result("t2");
        check("t2_busy_idle", busy, 1'b0);

        // 3: no result -> forced qNaN exactly TIMEOUT cycles after WAIT entry
        randomize_pair();
        load_pair();
        check("t3_aflat", A_flat, flat_of_a());
        check("t3_bflat", B_flat, flat_of_b());
        wait_result(cyc);
        check("t3_latency", cyc, TIMEOUT);
        check("t3_rdata", r_data, 32'h7FC0_0000);
        check("t3_rtmo", r_timeout, 1'b1);
        check("t3_masks", A_valid_out, 4'h0);
        release_result("t3");

        // 4: s_valid held through WAIT/RESULT; consumer stalls
        randomize_pair();
        load_pair();
        w = $urandom;
        s_data = w; s_valid = 1'b1;
        @(negedge clk);
        check("t4_sready_wait", s_ready, 1'b0);
        wait_result(cyc);
        check("t4_latency", cyc, TIMEOUT - 1);
        repeat (10) @(negedge clk);
        check("t4_rvalid_hold", r_valid, 1'b1);
        check("t4_rdata_hold", r_data, 32'h7FC0_0000);
        check("t4_aflat_hold", A_flat, flat_of_a());
        check("t4_sready_result", s_ready, 1'b0);
        release_result("t4");
        @(negedge clk);
        s_valid = 1'b0;
        mdl_a[0] = w;
        check("t4_word_in_a0", A_flat, flat_of_a());
        check("t4_busy", busy, 1'b1);

        // 5: reset mid-load discards the partial pair
        for (int k = 1; k < N; k++) send_word($urandom);
        send_word($urandom);
        send_word($urandom);
        rst_n = 1'b0;
        #1;
        check("t5_aflat", A_flat, 128'h0);
        check("t5_bflat", B_flat, 128'h0);
        check("t5_outs", {A_valid_out, r_data, r_valid, r_timeout, busy}, 39'h0);
        check("t5_sready", s_ready, 1'b1);
        s_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        randomize_pair();
        load_pair();
        check("t5_fresh_a", A_flat, flat_of_a());
        check("t5_fresh_b", B_flat, flat_of_b());
        check("t5_masks", A_valid_out, 4'hF);

        // 6: cos_valid in the final timeout cycle wins
        repeat (TIMEOUT - 1) @(negedge clk);
        check("t6_rvalid_pre", r_valid, 1'b0);
        cv = $urandom;
        cos_valid = 1'b1; cos_theta = cv;
        @(negedge clk);
        cos_valid = 1'b0;
        check("t6_rvalid", r_valid, 1'b1);
        check("t6_rdata", r_data, cv);
        check("t6_rtmo", r_timeout, 1'b0);
        release_result("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
